// File: rtl/mac_accum.sv
// -----------------------------------------------------------------------------
// mac_accum - multi-channel multiply/accumulate statistics block
//
// Purpose:
//   Accepts one unsigned sample per enabled cycle, tagged with a channel and a
//   mode (add r, add r*r, sub r, sub r*r). Stage 1 registers the operand
//   (r or r*r, zero-extended to ACC_W). Stage 2 does a read-modify-write of
//   the target channel accumulator, bumps its sample counter and updates its
//   sticky overflow/underflow flag. A registered read port presents the
//   accumulator and count of the selected readout channel.
//
// Optional feature (macro MAC_ACCUM_SAT_EN):
//   defined   - add overflow clamps to all-ones, sub underflow clamps to 0
//   undefined - arithmetic wraps modulo 2^ACC_W
//   In both builds the channel ovf flag is set when the limit is crossed.
//
// Ports:
//   clk_i     in   1      clock, rising edge
//   rst_ni    in   1      asynchronous active-low reset
//   en_i      in   1      sample strobe (clr_i, ch_i, mode_i, r_i sampled)
//   clr_i     in   1      with en_i: load the channel instead of accumulating
//   ch_i      in   CH_W   target channel (>= N_CH is dropped)
//   mode_i    in   2      00 add r, 01 add r*r, 10 sub r, 11 sub r*r
//   r_i       in   DATA_W sample
//   rd_ch_i   in   CH_W   readout channel select (>= N_CH reads 0)
//   y_o       out  ACC_W  registered accumulator of rd_ch_i
//   cnt_o     out  CNT_W  registered sample count of rd_ch_i
//   ovf_o     out  N_CH   sticky overflow/underflow flag per channel
//   busy_o    out  1      a sample is in flight in the pipeline
// -----------------------------------------------------------------------------
module mac_accum #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 96,
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] r_i,
    input  logic [CH_W-1:0]   rd_ch_i,
    output logic [ACC_W-1:0]  y_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [N_CH-1:0]   ovf_o,
    output logic              busy_o
);

    // Returns {limit_crossed, result}. The extra MSB of the ACC_W+1 wide
    // sum/difference is the carry (add) or borrow (sub).
    function automatic logic [ACC_W:0] commit_f(
        input logic [ACC_W-1:0] base,
        input logic [ACC_W-1:0] op,
        input logic             sub
    );
        logic [ACC_W:0]   full;
        logic [ACC_W-1:0] clamp;
        full  = sub ? ({1'b0, base} - {1'b0, op}) : ({1'b0, base} + {1'b0, op});
        clamp = sub ? {ACC_W{1'b0}} : {ACC_W{1'b1}};
`ifdef MAC_ACCUM_SAT_EN
        full[ACC_W-1:0] = full[ACC_W] ? clamp : full[ACC_W-1:0];
`else
        clamp = full[ACC_W-1:0];
        full[ACC_W-1:0] = clamp;
`endif
        return full;
    endfunction

    // Stage 1 signals
    logic                  ch_ok_s;
    logic [2*DATA_W-1:0]   sq_s;
    logic [ACC_W-1:0]      op_s;
    logic                  v1_q;
    logic [CH_W-1:0]       ch1_q;
    logic                  clr1_q;
    logic                  sub1_q;
    logic [ACC_W-1:0]      op1_q;
    logic                  v2_q;

    // Channel state and readout
    logic [ACC_W-1:0]      acc_q [N_CH];
    logic [ACC_W-1:0]      acc_d [N_CH];
    logic [CNT_W-1:0]      cnt_q [N_CH];
    logic [CNT_W-1:0]      cnt_d [N_CH];
    logic [N_CH-1:0]       ovf_q;
    logic [N_CH-1:0]       ovf_d;
    logic [ACC_W-1:0]      acc_cur_s;
    logic [CNT_W-1:0]      cnt_cur_s;
    logic [ACC_W:0]        res_s;
    logic [ACC_W-1:0]      y_d;
    logic [ACC_W-1:0]      y_q;
    logic [CNT_W-1:0]      cnt_rd_d;
    logic [CNT_W-1:0]      cnt_rd_q;

    // Out-of-range channels never enter the pipeline.
    assign ch_ok_s = (32'(ch_i) < 32'(N_CH));
    assign sq_s    = {{DATA_W{1'b0}}, r_i} * {{DATA_W{1'b0}}, r_i};
    assign op_s    = mode_i[0] ? ACC_W'(sq_s) : ACC_W'(r_i);

    // Stage 1 register: operand formation and valid tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q   <= 1'b0;
            ch1_q  <= {CH_W{1'b0}};
            clr1_q <= 1'b0;
            sub1_q <= 1'b0;
            op1_q  <= {ACC_W{1'b0}};
            v2_q   <= 1'b0;
        end else begin
            v1_q <= en_i & ch_ok_s;
            v2_q <= v1_q;
            if (en_i) begin
                ch1_q  <= ch_i;
                clr1_q <= clr_i;
                sub1_q <= mode_i[1];
                op1_q  <= op_s;
            end
        end
    end

    // Select the live accumulator/counter of the stage-1 channel (no stale copy).
    always_comb begin
        acc_cur_s = {ACC_W{1'b0}};
        cnt_cur_s = {CNT_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            acc_cur_s = (ch1_q == CH_W'(i)) ? acc_q[i] : acc_cur_s;
            cnt_cur_s = (ch1_q == CH_W'(i)) ? cnt_q[i] : cnt_cur_s;
        end
    end

    // A load behaves as an accumulate onto zero, so sub-load borrows when op != 0.
    assign res_s = commit_f(clr1_q ? {ACC_W{1'b0}} : acc_cur_s, op1_q, sub1_q);

    // Stage 2 next state: only the stage-1 channel changes; a load clears ovf first.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (v1_q && (ch1_q == CH_W'(i))) begin
                acc_d[i] = res_s[ACC_W-1:0];
                cnt_d[i] = clr1_q ? CNT_W'(1'b1) : (cnt_cur_s + CNT_W'(1'b1));
                ovf_d[i] = clr1_q ? res_s[ACC_W] : (ovf_q[i] | res_s[ACC_W]);
            end else begin
                acc_d[i] = acc_q[i];
                cnt_d[i] = cnt_q[i];
                ovf_d[i] = ovf_q[i];
            end
        end
    end

    // Readout mux: unmatched (out-of-range) selects fall through to zero.
    always_comb begin
        y_d      = {ACC_W{1'b0}};
        cnt_rd_d = {CNT_W{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            y_d      = (rd_ch_i == CH_W'(i)) ? acc_q[i] : y_d;
            cnt_rd_d = (rd_ch_i == CH_W'(i)) ? cnt_q[i] : cnt_rd_d;
        end
    end

    // Channel state and registered readout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= {ACC_W{1'b0}};
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            ovf_q    <= {N_CH{1'b0}};
            y_q      <= {ACC_W{1'b0}};
            cnt_rd_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q    <= ovf_d;
            y_q      <= y_d;
            cnt_rd_q <= cnt_rd_d;
        end
    end

    assign y_o    = y_q;
    assign cnt_o  = cnt_rd_q;
    assign ovf_o  = ovf_q;
    assign busy_o = v1_q | v2_q;

endmodule

// File: tb/tb_mac_accum.sv
// -----------------------------------------------------------------------------
// tb_mac_accum - self-checking bench for mac_accum.
// A reference model is updated as each sample is driven and the expected
// readout (y, cnt) is queued with its due cycle; a negedge monitor pops and
// compares when the readout select matches the queued channel. Settled
// checks use constants taken from the intended behaviour.
// CH_W is widened to 3 so that an out-of-range channel (5) is representable.
// -----------------------------------------------------------------------------
module tb_mac_accum;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 96;
    localparam int N_CH   = 4;
    localparam int CH_W   = 3;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [CH_W-1:0]   ch;
    logic [1:0]        mode;
    logic [DATA_W-1:0] r;
    logic [CH_W-1:0]   rd_ch;
    logic [ACC_W-1:0]  y;
    logic [CNT_W-1:0]  cnt;
    logic [N_CH-1:0]   ovf;
    logic              busy;

    typedef struct {
        int               due;
        logic [CH_W-1:0]  ch;
        logic [ACC_W-1:0] y;
        logic [CNT_W-1:0] cnt;
    } item_t;

    item_t            sb[$];
    logic [ACC_W-1:0] acc_m [N_CH];
    logic [CNT_W-1:0] cnt_m [N_CH];
    logic [N_CH-1:0]  ovf_m;
    logic [CH_W-1:0]  rd_ch_smp;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    int               exp_y4 [4] = '{11, 2, 3, 4};
    int               exp_c4 [4] = '{2, 1, 1, 1};
    logic [ACC_W-1:0] exp_sub_s;
    logic [ACC_W-1:0] exp_add_s;
    logic [ACC_W-1:0] exp_ld_s;

    mac_accum #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .ch_i(ch),
        .mode_i(mode), .r_i(r), .rd_ch_i(rd_ch), .y_o(y), .cnt_o(cnt),
        .ovf_o(ovf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_ch_smp <= rd_ch;
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            acc_m[i] = '0;
            cnt_m[i] = '0;
        end
        ovf_m = '0;
    endtask

    task automatic model_apply(input logic c, input logic [CH_W-1:0] cc,
                               input logic [1:0] m, input logic [DATA_W-1:0] rr);
        logic [63:0]      sq;
        logic [ACC_W-1:0] op;
        logic [ACC_W-1:0] base;
        logic [ACC_W:0]   full;
        sq   = {32'd0, rr} * {32'd0, rr};
        op   = m[0] ? {32'd0, sq} : {64'd0, rr};
        base = c ? 96'd0 : acc_m[cc];
        full = m[1] ? ({1'b0, base} - {1'b0, op}) : ({1'b0, base} + {1'b0, op});
`ifdef MAC_ACCUM_SAT_EN
        if (full[ACC_W]) full[ACC_W-1:0] = m[1] ? 96'd0 : {ACC_W{1'b1}};
`endif
        acc_m[cc] = full[ACC_W-1:0];
        cnt_m[cc] = c ? 32'd1 : cnt_m[cc] + 32'd1;
        ovf_m[cc] = c ? full[ACC_W] : (ovf_m[cc] | full[ACC_W]);
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic drive(input logic e, input logic c, input logic [CH_W-1:0] cc,
                         input logic [1:0] m, input logic [DATA_W-1:0] rr,
                         input logic [CH_W-1:0] rc);
        item_t it;
        @(posedge clk);
        #1;
        en = e; clr = c; ch = cc; mode = m; r = rr; rd_ch = rc;
        if (e && (cc < N_CH)) begin
            model_apply(c, cc, m, rr);
            it.due = cyc + 3;
            it.ch  = cc;
            it.y   = acc_m[cc];
            it.cnt = cnt_m[cc];
            sb.push_back(it);
        end
    endtask

    task automatic idle(input int n, input logic [CH_W-1:0] rc);
        repeat (n) drive(1'b0, 1'b0, 3'd0, 2'b00, 32'd0, rc);
    endtask

    task automatic readout(input logic [CH_W-1:0] rc);
        idle(1, rc);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: compare queued readouts on their due cycle.
    always @(negedge clk) begin : mon
        item_t it;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            check_val("sb_due", it.due, cyc);
            if (rd_ch_smp == it.ch) begin
                check_val("sb_y", y, it.y);
                check_val("sb_cnt", cnt, it.cnt);
            end
        end
    end

    initial begin
`ifdef MAC_ACCUM_SAT_EN
        exp_sub_s = 96'd0;
        exp_add_s = 96'd1;
        exp_ld_s  = 96'd0;
`else
        exp_sub_s = {ACC_W{1'b1}};
        exp_add_s = 96'd0;
        exp_ld_s  = {ACC_W{1'b1}} - 96'd1;
`endif
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; ch = '0; mode = '0; r = '0; rd_ch = '0;
        model_reset();

        // 1. reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_y", y, 0);
        check_val("rst_cnt", cnt, 0);
        check_val("rst_ovf", ovf, 0);
        check_val("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5, 3'd0);
        @(negedge clk);
        check_val("idle_y", y, 0);
        check_val("idle_cnt", cnt, 0);
        check_val("idle_ovf", ovf, 0);
        check_val("idle_busy", busy, 0);

        // 2. basic add and latency
        drive(1'b1, 1'b0, 3'd0, 2'b00, 32'd5, 3'd0);
        drive(1'b1, 1'b0, 3'd0, 2'b00, 32'd7, 3'd0);
        @(negedge clk);
        check_val("lat_busy", busy, 1);
        check_val("lat_y_k1", y, 0);
        idle(1, 3'd0);
        @(negedge clk);
        check_val("lat_y_k2", y, 0);
        idle(4, 3'd0);
        @(negedge clk);
        check_val("add_y", y, 12);
        check_val("add_cnt", cnt, 2);
        check_val("add_busy_low", busy, 0);

        // 3. square-load then subtract
        drive(1'b1, 1'b1, 3'd1, 2'b01, 32'hFFFF_FFFF, 3'd1);
        drive(1'b1, 1'b0, 3'd1, 2'b10, 32'd1, 3'd1);
        idle(4, 3'd1);
        @(negedge clk);
        check_val("sq_y", y, 96'hFFFF_FFFE_0000_0000);
        check_val("sq_cnt", cnt, 2);
        check_val("sq_ovf", ovf, 0);

        // 4. channel interleave, then a dropped out-of-range sample
        drive(1'b1, 1'b1, 3'd0, 2'b00, 32'd1, 3'd0);
        drive(1'b1, 1'b1, 3'd1, 2'b00, 32'd2, 3'd0);
        drive(1'b1, 1'b1, 3'd2, 2'b00, 32'd3, 3'd0);
        drive(1'b1, 1'b1, 3'd3, 2'b00, 32'd4, 3'd0);
        drive(1'b1, 1'b0, 3'd0, 2'b00, 32'd10, 3'd0);
        idle(4, 3'd0);
        for (int i = 0; i < 4; i++) begin
            readout(3'(i));
            check_val("ilv_y", y, exp_y4[i]);
            check_val("ilv_cnt", cnt, exp_c4[i]);
        end
        drive(1'b1, 1'b0, 3'd5, 2'b00, 32'd99, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check_val("drop_busy", busy, 0);
        idle(4, 3'd0);
        for (int i = 0; i < 4; i++) begin
            readout(3'(i));
            check_val("drop_y", y, exp_y4[i]);
            check_val("drop_cnt", cnt, exp_c4[i]);
        end
        check_val("drop_ovf", ovf, 0);
        readout(3'd5);
        check_val("oor_rd_y", y, 0);
        check_val("oor_rd_cnt", cnt, 0);

        // 5. underflow, sticky flag, sub-load, clear by load
        drive(1'b1, 1'b1, 3'd2, 2'b00, 32'd0, 3'd2);
        drive(1'b1, 1'b0, 3'd2, 2'b10, 32'd1, 3'd2);
        idle(4, 3'd2);
        @(negedge clk);
        check_val("unf_ovf", ovf, 4'b0100);
        check_val("unf_y", y, exp_sub_s);
        check_val("unf_cnt", cnt, 2);
        drive(1'b1, 1'b0, 3'd2, 2'b00, 32'd1, 3'd2);
        idle(4, 3'd2);
        @(negedge clk);
        check_val("ovf_sticky", ovf, 4'b0100);
        check_val("wrap_add_y", y, exp_add_s);
        drive(1'b1, 1'b1, 3'd3, 2'b10, 32'd2, 3'd3);
        idle(4, 3'd3);
        @(negedge clk);
        check_val("subld_ovf", ovf, 4'b1100);
        check_val("subld_y", y, exp_ld_s);
        check_val("subld_cnt", cnt, 1);
        drive(1'b1, 1'b1, 3'd2, 2'b00, 32'd7, 3'd2);
        idle(4, 3'd2);
        @(negedge clk);
        check_val("clr_ovf", ovf, 4'b1000);
        check_val("clr_y", y, 7);
        check_val("model_ovf", ovf, ovf_m);

        // 6. async reset mid-stream
        readout(3'd0);
        check_val("pre_rst_y", y, 11);
        drive(1'b1, 1'b0, 3'd0, 2'b00, 32'd3, 3'd0);
        drive(1'b1, 1'b0, 3'd0, 2'b00, 32'd4, 3'd0);
        @(negedge clk);
        check_val("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_val("arst_y", y, 0);
        check_val("arst_cnt", cnt, 0);
        check_val("arst_ovf", ovf, 0);
        check_val("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4, 3'd0);
        @(negedge clk);
        check_val("post_rst_y", y, 0);
        check_val("post_rst_cnt", cnt, 0);
        check_val("post_rst_ovf", ovf, 0);
        check_val("post_rst_busy", busy, 0);

        check_val("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
Multi-channel, parametrised successor to the single-channel random-sample accumulator. It accepts one DATA_W sample per enabled cycle, tagged with a channel and a mode (add, square-add, subtract, square-subtract). Results accumulate into one of N_CH wide accumulators, with per-channel sample counters and sticky overflow flags. A registered read port sits between the random-stimulus source and the statistics/readout logic.

Parameters:
DATA_W, 32, sample width (unsigned)
ACC_W, 96, accumulator width; must be >= 2*DATA_W
N_CH, 4, number of channels
CH_W, 2, channel index width; N_CH <= 2**CH_W
CNT_W, 32, per-channel sample counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  sample strobe; r, ch, mode, clr are sampled when en=1
clr  in  1  with en: load channel instead of accumulate
ch  in  CH_W  target channel for this sample
mode  in  2  00 add r, 01 add r*r, 10 sub r, 11 sub r*r
r  in  DATA_W  sample
rd_ch  in  CH_W  readout channel select
y  out  ACC_W  accumulator of rd_ch (registered)
cnt  out  CNT_W  sample count of rd_ch (registered)
ovf  out  N_CH  sticky overflow/underflow flag per channel
busy  out  1  1 while any sample is in flight in the pipeline

Behaviour:
- Reset (rst=0, async): all accumulators, counters, ovf, pipeline valids, y and cnt go to 0; busy=0. Deassertion is synchronised by the existing reset block upstream.
- Stage 1 (the cycle after en=1 is sampled):
  - Register v1=1, ch1, clr1, sub1=mode[1].
  - Register op1 = zero-extended r (mode[0]=0) or full-width product r*r (mode[0]=1), extended to ACC_W.
- Stage 2 (the next edge) commits to acc[ch1]:
  - clr1=1: acc = op1 (or 0-op1 for sub; this sets ovf if op1!=0). cnt = 1. ovf[ch1] is cleared first, then set only by this op.
  - clr1=0 add: acc = acc + op1. A carry out of ACC_W sets ovf[ch1].
  - clr1=0 sub: acc = acc - op1. A borrow sets ovf[ch1].
  - cnt[ch1] increments, wrapping modulo 2^CNT_W; counter wrap does not set ovf.
- Latency: en at edge k, commit at edge k+2. y/cnt show the committed value at edge k+3 when rd_ch=ch.
- Throughput: one sample per cycle.
- Back-to-back samples to the same channel are correct with no stall: stage 2 does read-modify-write of the current acc each cycle, and there is no stage-1 read of acc.
- Channels out of range (ch >= N_CH): the sample is dropped in stage 1 (v1=0). No state changes.
- y/cnt: registered every cycle from rd_ch. rd_ch >= N_CH reads 0.
- busy = v1 | v2.
- en=0 cycles insert bubbles; the accumulators hold.

Optional Feature:
Macro MAC_ACCUM_SAT_EN.
- Defined: arithmetic saturates. Add overflow clamps acc to 2^ACC_W-1; sub underflow clamps to 0. ovf is still set.
- Undefined: arithmetic wraps modulo 2^ACC_W, and ovf is set on wrap.
- All other behaviour is identical.

Test Plan:
1. Reset then idle. Hold rst=0 for 2 cycles, release, run 5 cycles with en=0 -> y=0, cnt=0, ovf=0, busy=0.
2. Basic add and latency. en=1, ch=0, mode=00, r=5 at edge k; r=7 at edge k+1; rd_ch=0.
   - At edge k+3: y=5.
   - At edge k+4: y=12, cnt=2. busy falls after the last commit.
3. Square and clr. ch=1, clr=1, mode=01, r=0xFFFFFFFF.
   - y = 0xFFFFFFFE00000001, cnt=1.
   - Next, mode=10 (sub), r=1 -> y = 0xFFFFFFFE00000000, cnt=2.
4. Channel interleave. Per cycle, ch 0,1,2,3,0 with r=1,2,3,4,10 and mode=00.
   - Sweep rd_ch -> y = 11,2,3,4 and cnt = 2,1,1,1.
   - ch=5 is dropped: no change anywhere.
5. Overflow/underflow.
   - ch=2: clr load 2^96-1 is not reachable directly, so instead sub r=1 from a freshly cleared 0 -> ovf[2]=1.
   - Wrap build: y = 2^96-1. With MAC_ACCUM_SAT_EN: y=0.
   - clr on ch2 clears ovf[2].
6. Async reset mid-stream. Pull rst low between edges while busy=1 -> all outputs 0 immediately, with no commit of in-flight samples after release.
